// File: rtl/hazard_pkg.sv
// Shared constants and elaboration helpers for the register hazard scoreboard.
package hazard_pkg;

  localparam int unsigned FWD_NONE = 0;
  localparam int unsigned FWD_FULL = 1;

  // Countdown width; kept at least 1 bit so a zero-depth pipe still elaborates.
  function automatic int unsigned cnt_w(input int unsigned pipe_depth);
    return (pipe_depth == 0) ? 1 : $clog2(pipe_depth + 1);
  endfunction

  function automatic bit params_legal(input int unsigned num_regs,
                                      input int unsigned reg_w,
                                      input int unsigned pipe_depth,
                                      input int unsigned load_lat);
    return (load_lat <= pipe_depth) && (num_regs > 0) &&
           (longint'(num_regs) <= (longint'(1) << reg_w));
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard countdown: reset, freeze-hold, issue load, then decrement to zero.
module hazard_sb_entry #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (freeze) begin
      cnt <= cnt;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard driving the ID-stage stall and a stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned REG_W       = 4,
  parameter int unsigned FORWARDING  = 1,
  parameter int unsigned PIPE_DEPTH  = 2,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  input  logic [REG_W-1:0]       src1,
  input  logic [REG_W-1:0]       src2,
  input  logic                   src1_valid,
  input  logic                   src2_valid,
  input  logic [REG_W-1:0]       dest,
  input  logic                   wb_en,
  input  logic                   mem_r_en,
  input  logic                   freeze,
  input  logic                   flush,
  output logic                   hazard_detect,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int unsigned CW = cnt_w(PIPE_DEPTH);
  localparam logic [CW-1:0] LOAD_V_LD  = CW'((FORWARDING == FWD_FULL) ? LOAD_LAT : PIPE_DEPTH);
  localparam logic [CW-1:0] LOAD_V_ALU = CW'((FORWARDING == FWD_FULL) ? 0 : PIPE_DEPTH);

  if (!params_legal(NUM_REGS, REG_W, PIPE_DEPTH, LOAD_LAT)) begin : g_bad_params
    $error("hazard_scoreboard: illegal parameters (LOAD_LAT > PIPE_DEPTH or NUM_REGS > 2**REG_W)");
  end

  logic [CW-1:0]       cnt [NUM_REGS];
  logic [NUM_REGS-1:0] load;
  logic [CW-1:0]       load_val;
  logic [CW-1:0]       rd1;
  logic [CW-1:0]       rd2;
  logic                issue;

  // Unmatched indices (>= NUM_REGS) fall through to zero.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (src1 == REG_W'(i)) rd1 = cnt[i];
      if (src2 == REG_W'(i)) rd2 = cnt[i];
    end
  end

  assign hazard_detect = issue_valid & ((src1_valid & (rd1 != '0)) |
                                        (src2_valid & (rd2 != '0)));
  assign issue    = issue_valid & ~hazard_detect & ~freeze & ~flush & wb_en;
  assign load_val = mem_r_en ? LOAD_V_LD : LOAD_V_ALU;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    assign load[g] = issue & (dest == REG_W'(g));

    hazard_sb_entry #(.CW(CW)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .freeze   (freeze),
      .load     (load[g]),
      .load_val (load_val),
      .cnt      (cnt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (hazard_detect & ~freeze & ~flush & (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench: forwarding, writeback-only and narrow-counter scoreboard instances.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [3:0] src1, src2, dest;
  logic       src1_valid, src2_valid, wb_en, mem_r_en, freeze, flush;

  logic        hd_f, hd_n, hd_s;
  logic [31:0] sc_f, sc_n;
  logic [3:0]  sc_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_fwd (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src1(src1), .src2(src2),
    .src1_valid(src1_valid), .src2_valid(src2_valid), .dest(dest), .wb_en(wb_en),
    .mem_r_en(mem_r_en), .freeze(freeze), .flush(flush),
    .hazard_detect(hd_f), .stall_cycles(sc_f)
  );

  hazard_scoreboard #(.NUM_REGS(12), .FORWARDING(0)) u_nofwd (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src1(src1), .src2(src2),
    .src1_valid(src1_valid), .src2_valid(src2_valid), .dest(dest), .wb_en(wb_en),
    .mem_r_en(mem_r_en), .freeze(freeze), .flush(flush),
    .hazard_detect(hd_n), .stall_cycles(sc_n)
  );

  hazard_scoreboard #(.FORWARDING(0), .STALL_CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .src1(src1), .src2(src2),
    .src1_valid(src1_valid), .src2_valid(src2_valid), .dest(dest), .wb_en(wb_en),
    .mem_r_en(mem_r_en), .freeze(freeze), .flush(flush),
    .hazard_detect(hd_s), .stall_cycles(sc_s)
  );

  typedef struct {
    logic       iv;
    logic [3:0] s1;
    logic       s1v;
    logic [3:0] s2;
    logic       s2v;
    logic [3:0] d;
    logic       we, mr, frz, fl, rs;
    logic       exp_hd;
    int         exp_sc;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input bit iv, input int s1, input bit s1v, input int s2,
                              input bit s2v, input int d, input bit we, input bit mr,
                              input bit frz, input bit fl, input bit rs,
                              input bit hd, input int sc);
    vec_t v;
    v.iv = iv; v.s1 = 4'(s1); v.s1v = s1v; v.s2 = 4'(s2); v.s2v = s2v;
    v.d = 4'(d); v.we = we; v.mr = mr; v.frz = frz; v.fl = fl; v.rs = rs;
    v.exp_hd = hd; v.exp_sc = sc;
    return v;
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid = v.iv; src1 = v.s1; src1_valid = v.s1v; src2 = v.s2; src2_valid = v.s2v;
    dest = v.d; wb_en = v.we; mem_r_en = v.mr; freeze = v.frz; flush = v.fl; rst = v.rs;
  endtask

  task automatic idle_inputs();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    // Read a register with a real instruction to prove every entry is zero.
    drive(mk(1, 3, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check({tag, ".rst_hd_f"}, hd_f, 0);
    check({tag, ".rst_hd_n"}, hd_n, 0);
    check({tag, ".rst_sc_f"}, sc_f, 0);
    check({tag, ".rst_sc_n"}, sc_n, 0);
    check({tag, ".rst_sc_s"}, sc_s, 0);
    idle_inputs();
    @(posedge clk); #1;
  endtask

  // sel 0 checks the forwarding instance, 1 the writeback-only instance.
  task automatic run_table(input string tag, input int sel);
    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i]);
      @(negedge clk);
      check($sformatf("%s[%0d].hd", tag, i), (sel == 0) ? hd_f : hd_n, tab[i].exp_hd);
      check($sformatf("%s[%0d].sc", tag, i), (sel == 0) ? sc_f : sc_n, tab[i].exp_sc);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Forwarding: load-use, back-to-back ALU, freeze window, flush, self-dependent load.
    do_reset("fwd");
    tab.delete();
    //               iv s1 v  s2 v  d  we mr fz fl rs  hd sc
    tab.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk(1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(1, 4, 1, 4, 1, 6, 1, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 1));
    tab.push_back(mk(1, 7, 1, 0, 1, 8, 1, 0, 1, 0, 0, 1, 1));
    tab.push_back(mk(1, 7, 1, 0, 1, 8, 1, 0, 1, 0, 0, 1, 1));
    tab.push_back(mk(1, 7, 1, 0, 1, 8, 1, 0, 1, 0, 0, 1, 1));
    tab.push_back(mk(1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 0, 1, 1));
    tab.push_back(mk(1, 7, 1, 0, 1, 8, 1, 0, 0, 0, 0, 0, 2));
    tab.push_back(mk(1, 0, 0, 0, 0, 8, 1, 1, 0, 1, 0, 0, 2));
    tab.push_back(mk(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 2));
    tab.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 2));
    tab.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 2));
    tab.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 3));
    tab.push_back(mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 3));
    tab.push_back(mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 4));
    run_table("fwd", 0);

    // Writeback-only, 12 registers: RAW, unread src2, WAW reload, flush, out-of-range, reset.
    do_reset("nofwd");
    tab.delete();
    //               iv s1 v  s2 v  d  we mr fz fl rs  hd sc
    tab.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 6, 1, 2, 1, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk(1, 1, 1, 6, 1, 2, 1, 0, 0, 0, 0, 1, 1));
    tab.push_back(mk(1, 1, 1, 6, 1, 2, 1, 0, 0, 0, 0, 0, 2));
    tab.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2));
    tab.push_back(mk(1, 6, 1, 1, 0, 9, 1, 0, 0, 0, 0, 0, 2));
    tab.push_back(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 2));
    tab.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 2));
    tab.push_back(mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 1, 2));
    tab.push_back(mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 1, 3));
    tab.push_back(mk(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 4));
    tab.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 1, 0, 0, 4));
    tab.push_back(mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    tab.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 0, 4));
    tab.push_back(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    tab.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 4));
    tab.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4));
    tab.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_table("nofwd", 1);

    // Saturation: ADD R1,R1 repeated stalls 2 of every 3 cycles on the 4-bit counter.
    do_reset("sat");
    begin
      int prev = 0;
      bit wrapped = 0;
      drive(mk(1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (int'(sc_s) < prev) wrapped = 1;
        prev = int'(sc_s);
        if (k == 21) check("sat.sc_after22", sc_s, 14);
      end
      check("sat.sc_final", sc_s, 15);
      check("sat.no_wrap", wrapped, 0);
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
